rob_queue: RTL and testbench

- Parametrised reorder-buffer storage: the circular queue behind the ROB dispatch stage.
- Allocates one entry per dispatched instruction and returns its ref id.
- Accepts out-of-order writebacks from WB_PORTS execution channels and retires entries in program order through a commit handshake.
- Serves one operand-lookup port for the issue stage; supports full flush on branch mispredict or exception.

---
 rtl/rob_queue_pkg.sv | 27 ++
 rtl/rob_ptr.sv | 24 ++
 rtl/rob_queue.sv | 143 ++++++++++++++
 tb/tb_rob_queue.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_queue_pkg.sv
// Shared reorder-buffer constants: default geometry and payload field offsets
// used by dispatch (packing) and commit (unpacking).
package rob_queue_pkg;

  localparam int ROB_DEPTH     = 16;
  localparam int ROB_ADDR_BUS  = 4;
  localparam int ROB_PAYLOAD_W = 128;
  localparam int ROB_WB_PORTS  = 2;
  localparam int ROB_DATA_W    = 32;

  // Payload layout: the queue treats the payload as opaque; these offsets
  // describe how dispatch packs it and how commit unpacks it.
  localparam int ROB_PL_PC_LSB  = 0;
  localparam int ROB_PL_PC_W    = 64;
  localparam int ROB_PL_RD_LSB  = 64;
  localparam int ROB_PL_RD_W    = 5;
  localparam int ROB_PL_OP_LSB  = 69;
  localparam int ROB_PL_OP_W    = 8;
  localparam int ROB_PL_EXC_LSB = 77;
  localparam int ROB_PL_EXC_W   = 6;

  typedef struct packed {
    logic valid;
    logic done;
  } rob_flags_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrapping queue pointer with an extra wrap bit; synchronous clear and increment.
module rob_ptr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_reg;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      ptr_reg <= '0;
    end else if (inc) begin
      ptr_reg <= ptr_reg + 1'b1;
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/rob_queue.sv
// Reorder-buffer circular queue: in-order allocate/commit, out-of-order writeback.
// Optional macro ROB_WB_BYPASS_EN forwards same-cycle writebacks to the query port.
module rob_queue
  import rob_queue_pkg::*;
#(
  parameter int DEPTH     = ROB_DEPTH,
  parameter int ADDR_W    = ROB_ADDR_BUS,
  parameter int PAYLOAD_W = ROB_PAYLOAD_W,
  parameter int WB_PORTS  = ROB_WB_PORTS,
  parameter int DATA_W    = ROB_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc_en,
  input  logic [PAYLOAD_W-1:0]       alloc_payload,
  output logic                       alloc_ready,
  output logic [ADDR_W-1:0]          alloc_id,
  input  logic [WB_PORTS-1:0]        wb_valid,
  input  logic [WB_PORTS*ADDR_W-1:0] wb_id,
  input  logic [WB_PORTS*DATA_W-1:0] wb_value,
  input  logic [ADDR_W-1:0]          query_id,
  output logic                       query_done,
  output logic [DATA_W-1:0]          query_value,
  output logic                       commit_valid,
  output logic [ADDR_W-1:0]          commit_id,
  output logic [PAYLOAD_W-1:0]       commit_payload,
  output logic [DATA_W-1:0]          commit_value,
  input  logic                       commit_ack,
  input  logic                       flush,
  output logic [ADDR_W:0]            count
);

  logic [ADDR_W:0]    head_ptr;
  logic [ADDR_W:0]    tail_ptr;
  logic [ADDR_W-1:0]  head_idx;
  logic [ADDR_W-1:0]  tail_idx;
  logic               full;
  logic               alloc_fire;
  logic               commit_fire;
  logic [DEPTH-1:0]   valid_vec;
  logic [DEPTH-1:0]   done_vec;
  logic [DATA_W-1:0]  value_arr   [DEPTH];
  logic [PAYLOAD_W-1:0] payload_arr [DEPTH];

  assign head_idx    = head_ptr[ADDR_W-1:0];
  assign tail_idx    = tail_ptr[ADDR_W-1:0];
  assign full        = (head_idx == tail_idx) && (head_ptr[ADDR_W] != tail_ptr[ADDR_W]);
  assign alloc_ready = !full;
  assign alloc_fire  = alloc_en && alloc_ready;
  assign commit_fire = commit_ack && commit_valid;
  assign count       = tail_ptr - head_ptr;

  rob_ptr #(.W(ADDR_W + 1)) u_head (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (commit_fire),
    .ptr (head_ptr)
  );

  rob_ptr #(.W(ADDR_W + 1)) u_tail (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (alloc_fire),
    .ptr (tail_ptr)
  );

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      rob_flags_t           flags_reg;
      logic [DATA_W-1:0]    value_reg;
      logic [PAYLOAD_W-1:0] payload_reg;
      logic                 alloc_hit;
      logic                 commit_hit;
      logic                 wb_hit;
      logic [DATA_W-1:0]    wb_data;

      assign alloc_hit  = alloc_fire && (tail_idx == ADDR_W'(gi));
      assign commit_hit = commit_fire && (head_idx == ADDR_W'(gi));

      // Ascending scan so the highest-numbered matching channel wins.
      always_comb begin
        wb_hit  = 1'b0;
        wb_data = '0;
        for (int k = 0; k < WB_PORTS; k++) begin
          if (wb_valid[k] && (wb_id[k*ADDR_W +: ADDR_W] == ADDR_W'(gi))) begin
            wb_hit  = 1'b1;
            wb_data = wb_value[k*DATA_W +: DATA_W];
          end
        end
      end

      // Writebacks only land on entries that were already allocated last cycle.
      always_ff @(posedge clk) begin
        if (!rst || flush) begin
          flags_reg <= '0;
        end else begin
          if (alloc_hit) begin
            flags_reg   <= '{valid: 1'b1, done: 1'b0};
            value_reg   <= '0;
            payload_reg <= alloc_payload;
          end
          if (wb_hit && flags_reg.valid) begin
            flags_reg.done <= 1'b1;
            value_reg      <= wb_data;
          end
          if (commit_hit) begin
            flags_reg <= '0;
          end
        end
      end

      assign valid_vec[gi]   = flags_reg.valid;
      assign done_vec[gi]    = flags_reg.done;
      assign value_arr[gi]   = value_reg;
      assign payload_arr[gi] = payload_reg;
    end
  endgenerate

  assign commit_valid   = valid_vec[head_idx] && done_vec[head_idx];
  assign commit_id      = head_idx;
  assign commit_payload = payload_arr[head_idx];
  assign commit_value   = value_arr[head_idx];
  assign alloc_id       = tail_idx;

  always_comb begin
    query_done  = valid_vec[query_id] && done_vec[query_id];
    query_value = value_arr[query_id];
`ifdef ROB_WB_BYPASS_EN
    for (int k = 0; k < WB_PORTS; k++) begin
      if (wb_valid[k] && (wb_id[k*ADDR_W +: ADDR_W] == query_id) && valid_vec[query_id]) begin
        query_done  = 1'b1;
        query_value = wb_value[k*DATA_W +: DATA_W];
      end
    end
`else
    // Without forwarding, a writeback becomes visible here one cycle later.
`endif
  end

endmodule

// File: tb/tb_rob_queue.sv
// Directed self-checking bench for rob_queue (DEPTH=4) with an in-order commit scoreboard.
module tb_rob_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int PW    = 16;
  localparam int NP    = 2;
  localparam int DW    = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             alloc_en;
  logic [PW-1:0]    alloc_payload;
  logic             alloc_ready;
  logic [AW-1:0]    alloc_id;
  logic [NP-1:0]    wb_valid;
  logic [NP*AW-1:0] wb_id;
  logic [NP*DW-1:0] wb_value;
  logic [AW-1:0]    query_id;
  logic             query_done;
  logic [DW-1:0]    query_value;
  logic             commit_valid;
  logic [AW-1:0]    commit_id;
  logic [PW-1:0]    commit_payload;
  logic [DW-1:0]    commit_value;
  logic             commit_ack;
  logic             flush;
  logic [AW:0]      count;

  rob_queue #(
    .DEPTH(DEPTH), .ADDR_W(AW), .PAYLOAD_W(PW), .WB_PORTS(NP), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .alloc_en(alloc_en), .alloc_payload(alloc_payload),
    .alloc_ready(alloc_ready), .alloc_id(alloc_id),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value),
    .query_id(query_id), .query_done(query_done), .query_value(query_value),
    .commit_valid(commit_valid), .commit_id(commit_id),
    .commit_payload(commit_payload), .commit_value(commit_value),
    .commit_ack(commit_ack), .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] id;
    logic [PW-1:0] payload;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] exp_val [DEPTH];
  logic [AW-1:0] exp_tail;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_en = 1'b0; alloc_payload = '0; wb_valid = '0; wb_id = '0; wb_value = '0;
    commit_ack = 1'b0; flush = 1'b0;
  endtask

  task automatic model_clear();
    sb_q.delete();
    exp_tail = '0;
  endtask

  task automatic do_alloc(input logic [PW-1:0] pl);
    exp_t e;
    chk("alloc_ready", alloc_ready, 1'b1);
    chk("alloc_id", alloc_id, exp_tail);
    e.id = exp_tail; e.payload = pl;
    sb_q.push_back(e);
    exp_val[exp_tail] = '0;
    alloc_en = 1'b1; alloc_payload = pl;
    step();
    alloc_en = 1'b0;
    exp_tail = exp_tail + 1'b1;
    $display("alloc id=%0d payload=0x%0h count=%0d", e.id, pl, count);
  endtask

  task automatic do_wb(input int ch, input logic [AW-1:0] id, input logic [DW-1:0] v);
    wb_valid[ch] = 1'b1;
    wb_id[ch*AW +: AW] = id;
    wb_value[ch*DW +: DW] = v;
    exp_val[id] = v;
    step();
    wb_valid = '0;
    $display("wb ch=%0d id=%0d value=0x%0h", ch, id, v);
  endtask

  task automatic do_commit();
    exp_t e;
    chk("commit_valid", commit_valid, 1'b1);
    if (sb_q.size() == 0) begin
      chk("commit_scoreboard_nonempty", 1'b0, 1'b1);
    end else begin
      e = sb_q.pop_front();
      chk("commit_id", commit_id, e.id);
      chk("commit_payload", commit_payload, e.payload);
      chk("commit_value", commit_value, exp_val[e.id]);
      $display("commit id=%0d payload=0x%0h value=0x%0h", commit_id, commit_payload, commit_value);
    end
    commit_ack = 1'b1;
    step();
    commit_ack = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    model_clear();
    chk("flush_count", count, '0);
    $display("flush count=%0d", count);
  endtask

  initial begin
    idle_inputs();
    query_id = '0;
    rst = 1'b0;
    model_clear();
    repeat (2) step();
    rst = 1'b1;
    chk("rst_alloc_ready", alloc_ready, 1'b1);
    chk("rst_alloc_id", alloc_id, '0);
    chk("rst_commit_valid", commit_valid, 1'b0);
    chk("rst_commit_id", commit_id, '0);
    chk("rst_count", count, '0);
    chk("rst_query_done", query_done, 1'b0);
    $display("reset released count=%0d", count);

    // Fill to full, then a refused fifth allocation.
    for (int i = 0; i < DEPTH; i++) do_alloc(PW'(16'h100 + i));
    chk("full_count", count, 3'd4);
    chk("full_alloc_ready", alloc_ready, 1'b0);
    alloc_en = 1'b1; alloc_payload = 16'hDEAD;
    step();
    alloc_en = 1'b0;
    chk("refused_alloc_id", alloc_id, '0);
    chk("refused_count", count, 3'd4);
    // commit_ack while head not done is ignored
    commit_ack = 1'b1;
    step();
    commit_ack = 1'b0;
    chk("ignored_ack_count", count, 3'd4);
    do_flush();

    // Out-of-order writeback, in-order retire.
    for (int i = 0; i < 3; i++) do_alloc(PW'(16'h200 + i));
    do_wb(0, 2'd2, 32'h22);
    chk("ooo_no_commit", commit_valid, 1'b0);
    wb_valid[0] = 1'b1; wb_id[0 +: AW] = 2'd0; wb_value[0 +: DW] = 32'h11;
    exp_val[0] = 32'h11;
    #1;
    chk("wb_head_same_cycle", commit_valid, 1'b0);
    step();
    wb_valid = '0;
    do_commit();
    chk("stall_on_id1", commit_valid, 1'b0);
    do_wb(1, 2'd1, 32'h33);
    do_commit();
    do_commit();
    chk("drain_count", count, '0);
    do_flush();

    // Both channels hit the same id: highest channel wins.
    do_alloc(16'h300);
    do_alloc(16'h301);
    do_wb(0, 2'd0, 32'h01);
    wb_valid = 2'b11;
    wb_id = {2'd1, 2'd1};
    wb_value = {32'hBB, 32'hAA};
    exp_val[1] = 32'hBB;
    step();
    wb_valid = '0;
    do_commit();
    do_commit();
    do_flush();

    // Full with commit_ack and alloc_en together: commit only, then wrap.
    for (int i = 0; i < DEPTH; i++) do_alloc(PW'(16'h400 + i));
    do_wb(0, 2'd0, 32'h44);
    chk("full_commit_valid", commit_valid, 1'b1);
    chk("full_ready_low", alloc_ready, 1'b0);
    begin
      exp_t e;
      e = sb_q.pop_front();
      chk("full_commit_id", commit_id, e.id);
      chk("full_commit_value", commit_value, exp_val[e.id]);
    end
    commit_ack = 1'b1; alloc_en = 1'b1; alloc_payload = 16'hBAD0;
    step();
    commit_ack = 1'b0; alloc_en = 1'b0;
    chk("full_ack_alloc_count", count, 3'd3);
    do_alloc(16'h404);
    chk("wrap_count", count, 3'd4);
    do_flush();

    // Flush, then reset, each with alloc/wb/commit in the same cycle.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 3; i++) do_alloc(PW'(16'h500 + i));
      do_wb(0, 2'd0, 32'h55);
      chk("pre_flush_commit_valid", commit_valid, 1'b1);
      alloc_en = 1'b1; alloc_payload = 16'h5FF;
      commit_ack = 1'b1;
      wb_valid = 2'b01; wb_id = {2'd0, 2'd1}; wb_value = {32'h0, 32'h66};
      if (pass == 0) flush = 1'b1; else rst = 1'b0;
      step();
      idle_inputs();
      rst = 1'b1;
      model_clear();
      query_id = 2'd1;
      #1;
      chk("flush_rst_count", count, '0);
      chk("flush_rst_commit_valid", commit_valid, 1'b0);
      chk("flush_rst_alloc_id", alloc_id, '0);
      chk("flush_rst_query_done", query_done, 1'b0);
      $display("flush pass=%0d count=%0d alloc_id=%0d", pass, count, alloc_id);
    end

    // Query port: same-cycle writeback visibility, and ignored stray writeback.
    for (int i = 0; i < 3; i++) do_alloc(PW'(16'h600 + i));
    query_id = 2'd2;
    wb_valid = 2'b01; wb_id = {2'd0, 2'd2}; wb_value = {32'h0, 32'h5A};
    exp_val[2] = 32'h5A;
    #1;
`ifdef ROB_WB_BYPASS_EN
    chk("bypass_query_done", query_done, 1'b1);
    chk("bypass_query_value", query_value, 32'h5A);
`else
    chk("nobypass_query_done", query_done, 1'b0);
`endif
    step();
    wb_valid = '0;
    chk("query_done_next", query_done, 1'b1);
    chk("query_value_next", query_value, 32'h5A);
    $display("query id=2 done=%0d value=0x%0h", query_done, query_value);
    do_wb(1, 2'd3, 32'h77);
    query_id = 2'd3;
    #1;
    chk("stray_wb_ignored", query_done, 1'b0);
    chk("stray_count", count, 3'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
